vga_sync_rx: RTL
================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_TOTAL, default 800: nominal clocks per line.
REQ-002 Parameter V_TOTAL, default 525: nominal lines per frame.
REQ-003 Parameter HVA, default 640: visible pixels per line.
REQ-004 Parameter VVA, default 480: visible lines per frame.
REQ-005 Parameter HSYNC_START, default 656: hpos value assigned on the hsync falling edge.
REQ-006 Parameter VSYNC_START, default 491: vpos value assigned on the vsync falling edge.
REQ-007 clk  input  1  pixel clock; the block has one clock.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 hsync_in  input  1  active-low horizontal sync, synchronous to clk.
REQ-010 vsync_in  input  1  active-low vertical sync, synchronous to clk.
REQ-011 hpos  output  10  recovered pixel column.
REQ-012 vpos  output  10  recovered line number.
REQ-013 pxl_en  output  1  high when locked, hpos<HVA and vpos<VVA.
REQ-014 locked  output  1  high in state LOCKED.
REQ-015 h_meas  output  10  last measured line length in clocks.
REQ-016 v_meas  output  10  last measured frame length in lines.
REQ-017 err_cnt  output  8  count of lock losses, saturating at 255.

Function
REQ-018 The block SHALL register each sync input once (s), keep the previous sample (p), and detect a falling edge when p=1 and s=0; all edge effects SHALL appear after the following clock (2 clocks from pin to outputs).
REQ-019 hcnt (10 bit) SHALL increment every clock, saturate at 1023, and clear to 0 on an hsync edge; h_meas SHALL load hcnt+1 on that edge.
REQ-020 hpos SHALL load HSYNC_START on an hsync edge, wrap from H_TOTAL-1 to 0, and otherwise increment.
REQ-021 vpos SHALL increment when hpos wraps and wrap from V_TOTAL-1 to 0; a vsync edge SHALL load VSYNC_START and SHALL take priority over the hpos-wrap increment.
REQ-022 lcnt SHALL count hsync edges; on a vsync edge v_meas SHALL load lcnt, plus 1 if an hsync edge occurs in the same cycle, and lcnt SHALL clear to 0, or to 1 in that same-cycle case.
REQ-023 A line SHALL be bad if an hsync edge gives hcnt+1 != H_TOTAL, or if hcnt reaches 1023 (timeout). A frame SHALL be bad if the captured v_meas != V_TOTAL or it contained a bad line.
REQ-024 The FSM SHALL have states SEARCH, CHECK and LOCKED.
  - SEARCH -> CHECK on the first vsync edge.
  - CHECK -> LOCKED on a vsync edge closing a good frame; a bad frame keeps CHECK and restarts the check.
  - LOCKED -> SEARCH immediately on a bad line or bad frame, and err_cnt increments (saturating).
REQ-025 pxl_en SHALL be registered and coincident with hpos/vpos; it SHALL fall in the same cycle that locked falls.
REQ-026 Before the first hsync edge, hpos/vpos SHALL free-run from 0 under the REQ-020/021 wrap rules.

Reset
REQ-027 While rst=1 all outputs SHALL be 0, the FSM SHALL be in SEARCH, all counters SHALL be 0, and the s/p sync registers SHALL be 1.
REQ-028 Reset asserted mid-frame SHALL take effect asynchronously, and no edge SHALL be detected on the first clock after release.

Verification
REQ-029 Nominal 800x525 sync (hsync low at counts 656-751, vsync low on lines 491-492) -> locked=1 at the second vsync edge; h_meas=800; v_meas=525; err_cnt=0.
REQ-030 Locked stream with one line of 801 clocks -> locked=0 and pxl_en=0 two clocks after the edge; err_cnt=1; locked again two vsync edges later.
REQ-031 hsync held high for 1100 clocks while locked -> SEARCH at hcnt=1023; err_cnt increments once.
REQ-032 Frame of 524 lines during CHECK -> v_meas=524; state stays CHECK; no err_cnt change.
REQ-033 Locked stream -> pxl_en=1 exactly for hpos 0..639 and vpos 0..479; hpos=656 on the cycle after each hsync edge is detected.
REQ-034 rst pulsed mid-line while locked -> outputs 0 immediately; relock after two frames; err_cnt=0.

Source files
------------

// File: rtl/vga_sync_rx.sv
// ---------------------------------------------------------------------------
// vga_sync_rx
//
// Recovers the pixel raster position from a pair of active-low VGA sync
// inputs. It measures line and frame lengths, and reports lock once a whole
// frame with nominal timing has been seen. The block runs in the single pixel
// clock domain. Both sync inputs must already be synchronous to clk.
//
// Parameters
//   H_TOTAL      nominal clocks per line
//   V_TOTAL      nominal lines per frame
//   HVA / VVA    visible pixels per line / visible lines per frame
//   HSYNC_START  hpos value taken on an hsync falling edge
//   VSYNC_START  vpos value taken on a vsync falling edge
//
// Ports
//   clk, rst     pixel clock, asynchronous active-high reset
//   hsync_in     active-low horizontal sync
//   vsync_in     active-low vertical sync
//   hpos, vpos   recovered pixel column / line
//   pxl_en       locked and inside the visible area, aligned with hpos/vpos
//   locked       FSM is in LOCKED
//   h_meas       last measured line length in clocks
//   v_meas       last measured frame length in lines
//   err_cnt      number of lock losses, saturating at 255
// ---------------------------------------------------------------------------
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int HVA         = 640,
  parameter int VVA         = 480,
  parameter int HSYNC_START = 656,
  parameter int VSYNC_START = 491
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       pxl_en,
  output logic       locked,
  output logic [9:0] h_meas,
  output logic [9:0] v_meas,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] H_VIS   = 10'(HVA);
  localparam logic [9:0] V_VIS   = 10'(VVA);
  localparam logic [9:0] H_START = 10'(HSYNC_START);
  localparam logic [9:0] V_START = 10'(VSYNC_START);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  state_t     state_q, state_d;
  logic       hs_s_q, hs_s_d, hs_p_q, hs_p_d;
  logic       vs_s_q, vs_s_d, vs_p_q, vs_p_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [9:0] lcnt_q, lcnt_d;
  logic [9:0] h_meas_q, h_meas_d;
  logic [9:0] v_meas_q, v_meas_d;
  logic [7:0] err_q, err_d;
  logic       pxl_en_q, pxl_en_d;
  logic       frame_bad_q, frame_bad_d;

  logic       h_edge, v_edge, h_wrap;
  logic       line_bad, frame_bad_now;
  logic [9:0] hcnt_inc, v_meas_new;

  // Sync sampling, edge detection, and the line/frame counters.
  always_comb begin
    hs_s_d = hsync_in;
    hs_p_d = hs_s_q;
    vs_s_d = vsync_in;
    vs_p_d = vs_s_q;

    h_edge   = hs_p_q & ~hs_s_q;
    v_edge   = vs_p_q & ~vs_s_q;
    hcnt_inc = hcnt_q + 10'd1;

    // hcnt holds at its maximum so that a missing hsync reads as a timeout.
    if (h_edge) begin
      hcnt_d = '0;
    end else if (hcnt_q == CNT_MAX) begin
      hcnt_d = hcnt_q;
    end else begin
      hcnt_d = hcnt_inc;
    end
    h_meas_d = h_edge ? hcnt_inc : h_meas_q;

    // The raster free-runs between sync edges, so it keeps counting through
    // a missing pulse.
    h_wrap = !h_edge && (hpos_q == H_LAST);
    if (h_edge) begin
      hpos_d = H_START;
    end else if (h_wrap) begin
      hpos_d = '0;
    end else begin
      hpos_d = hpos_q + 10'd1;
    end

    // A vsync edge overrides an hpos wrap in the same cycle.
    if (v_edge) begin
      vpos_d = V_START;
    end else if (h_wrap) begin
      vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
    end else begin
      vpos_d = vpos_q;
    end

    // An hsync edge that coincides with vsync belongs to the closing frame
    // and also opens the new line count.
    v_meas_new = lcnt_q + {9'd0, h_edge};
    v_meas_d   = v_edge ? v_meas_new : v_meas_q;
    if (v_edge) begin
      lcnt_d = {9'd0, h_edge};
    end else if (h_edge && lcnt_q != CNT_MAX) begin
      lcnt_d = lcnt_q + 10'd1;
    end else begin
      lcnt_d = lcnt_q;
    end
  end

  // Line and frame quality. The timeout term stays asserted while hcnt sits
  // at its maximum, so a frame restarted during a timeout is still bad.
  always_comb begin
    line_bad      = (h_edge && (hcnt_inc != H_TOT)) ||
                    (!h_edge && (hcnt_q == CNT_MAX));
    frame_bad_now = frame_bad_q || line_bad || (v_meas_new != V_TOT);
    frame_bad_d   = v_edge ? 1'b0 : (frame_bad_q | line_bad);
  end

  // Lock FSM next state, error counter, and the visible-area enable.
  // pxl_en is computed from the next state so that it drops together with
  // locked.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      SEARCH: begin
        if (v_edge) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (v_edge && !frame_bad_now) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (line_bad || (v_edge && frame_bad_now)) begin
          state_d = SEARCH;
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    pxl_en_d = (state_d == LOCKED) && (hpos_d < H_VIS) && (vpos_d < V_VIS);
  end

  // State registers. The sync samplers reset to the idle-high level so that
  // no edge can be seen on the first clock after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_s_q      <= 1'b1;
      hs_p_q      <= 1'b1;
      vs_s_q      <= 1'b1;
      vs_p_q      <= 1'b1;
      state_q     <= SEARCH;
      hcnt_q      <= '0;
      hpos_q      <= '0;
      vpos_q      <= '0;
      lcnt_q      <= '0;
      h_meas_q    <= '0;
      v_meas_q    <= '0;
      err_q       <= '0;
      pxl_en_q    <= 1'b0;
      frame_bad_q <= 1'b0;
    end else begin
      hs_s_q      <= hs_s_d;
      hs_p_q      <= hs_p_d;
      vs_s_q      <= vs_s_d;
      vs_p_q      <= vs_p_d;
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      lcnt_q      <= lcnt_d;
      h_meas_q    <= h_meas_d;
      v_meas_q    <= v_meas_d;
      err_q       <= err_d;
      pxl_en_q    <= pxl_en_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  assign hpos    = hpos_q;
  assign vpos    = vpos_q;
  assign pxl_en  = pxl_en_q;
  assign locked  = (state_q == LOCKED);
  assign h_meas  = h_meas_q;
  assign v_meas  = v_meas_q;
  assign err_cnt = err_q;

endmodule
